// File: rtl/multi_ifetch_ir_if.sv
// Instruction-memory read bus: one-word level request / single-cycle ack.
// The fetch unit is the master; the instruction memory is the slave.
interface multi_ifetch_ir_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/multi_ifetch_ir.sv
// Instruction fetch + instruction register for the multi-cycle CPU.
// A fetch command issues one word read over the req/ack bus; the returned
// word is latched into the IR and split into MIPS fields.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch that receives
// no ack within TIMEOUT_CYCLES cycles of waiting.
module multi_ifetch_ir #(
   parameter int          ADDR_W         = 32,
   parameter logic [31:0] RESET_INSTR    = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_start,
   input  logic [ADDR_W-1:0] pc_in,
   multi_ifetch_ir_if.master mem,
   output logic [31:0]       instr,
   output logic              ir_valid,
   output logic              busy,
   output logic              fetch_err,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [15:0]       imm16,
   output logic [25:0]       jaddr
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t            state_q;
   logic [31:0]       instr_q;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic              ir_valid_q;
   logic              err_q;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q;
`endif

   // Fetch FSM: issues the request, captures the ack data, flags errors
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         instr_q    <= RESET_INSTR;
         req_q      <= 1'b0;
         addr_q     <= '0;
         ir_valid_q <= 1'b0;
         err_q      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         // status strobes are single-cycle pulses by default
         ir_valid_q <= 1'b0;
         err_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // mem_ack arriving here is stray and deliberately ignored
               if (fetch_start) begin
                  if (pc_in[1:0] == 2'b00) begin
                     addr_q  <= pc_in;
                     req_q   <= 1'b1;
                     state_q <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                     cnt_q   <= '0;
`endif
                  end else begin
                     // misaligned word address: reject without touching the bus
                     err_q <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               // fetch_start is ignored while a fetch is outstanding; an ack
               // takes priority over an expiring timeout
               if (mem.mem_ack) begin
                  instr_q    <= mem.mem_rdata;
                  req_q      <= 1'b0;
                  ir_valid_q <= 1'b1;
                  state_q    <= S_IDLE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (cnt_q == CNT_LAST) begin
                  req_q   <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   // Registered outputs and combinational field slices of the IR
   always_comb begin
      mem.mem_req  = req_q;
      mem.mem_addr = addr_q;
      instr        = instr_q;
      ir_valid     = ir_valid_q;
      busy         = (state_q == S_WAIT);
      fetch_err    = err_q;
      opcode       = instr_q[31:26];
      rs           = instr_q[25:21];
      rt           = instr_q[20:16];
      rd           = instr_q[15:11];
      shamt        = instr_q[10:6];
      funct        = instr_q[5:0];
      imm16        = instr_q[15:0];
      jaddr        = instr_q[25:0];
   end

endmodule
